// File: rtl/cci_mpf_prim_rr_arb_onehot_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cci_mpf_prim_rr_arb_onehot_pkg
// Description : Shared constants for the registered round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package cci_mpf_prim_rr_arb_onehot_pkg;

  // Legal span of the requestor count
  localparam int c_n_req_min = 2;
  localparam int c_n_req_max = 64;

endpackage : cci_mpf_prim_rr_arb_onehot_pkg
`default_nettype wire

// File: rtl/cci_mpf_prim_onehot_to_bin.sv
`default_nettype none
// ============================================================================
// Module      : cci_mpf_prim_onehot_to_bin
// Description : One-hot to binary index decode. An all-zero input gives 0.
// Revision    : 1.0 - initial release
// ============================================================================
module cci_mpf_prim_onehot_to_bin
  import cci_mpf_prim_rr_arb_onehot_pkg::*;
#(
  parameter int ONEHOT_WIDTH = 16,
  parameter int BIN_WIDTH    = $clog2(ONEHOT_WIDTH)
) (
  input  logic [ONEHOT_WIDTH-1:0] onehot,
  output logic [BIN_WIDTH-1:0]    bin
);

  // OR together the indices of all set bits; exact for a one-hot input
  always_comb begin
    bin = '0;
    for (int i = 0; i < ONEHOT_WIDTH; i++) begin
      if (onehot[i]) begin
        bin = bin | BIN_WIDTH'(i);
      end
    end
  end

endmodule : cci_mpf_prim_onehot_to_bin
`default_nettype wire

// File: rtl/cci_mpf_prim_rr_arb_onehot.sv
`default_nettype none
// ============================================================================
// Module      : cci_mpf_prim_rr_arb_onehot
// Description : Registered round-robin arbiter with one-hot grant, binary
//               grant index, valid/ready handshake and optional grant lock.
// Revision    : 1.0 - initial release
// ============================================================================
module cci_mpf_prim_rr_arb_onehot
  import cci_mpf_prim_rr_arb_onehot_pkg::*;
#(
  parameter int N_REQ     = 16,
  parameter int BIN_WIDTH = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_REQ-1:0]     req,
  input  logic                 lock,
  output logic                 grant_valid,
  input  logic                 grant_ready,
  output logic [N_REQ-1:0]     grant_onehot,
  output logic [BIN_WIDTH-1:0] grant_bin,
  output logic [N_REQ-1:0]     req_ack
);

  if (N_REQ < c_n_req_min || N_REQ > c_n_req_max) begin : g_bad_n_req
    $error("cci_mpf_prim_rr_arb_onehot: N_REQ=%0d outside 2..64", N_REQ);
  end

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  localparam logic [BIN_WIDTH:0]   c_n_req_w = (BIN_WIDTH+1)'(N_REQ);
  localparam logic [BIN_WIDTH-1:0] c_last    = BIN_WIDTH'(N_REQ - 1);

  state_t               r_state;
  logic [N_REQ-1:0]     r_grant_onehot;
  logic [BIN_WIDTH-1:0] r_ptr;
  logic                 r_locked;

  logic                 w_accept;
  logic                 w_arb;
  logic                 w_lock_hit;
  logic [N_REQ-1:0]     w_elig;
  logic [BIN_WIDTH-1:0] w_ptr_next;
  logic [N_REQ-1:0]     w_rot;
  logic [BIN_WIDTH-1:0] w_off;
  logic [BIN_WIDTH:0]   w_sum;
  logic [BIN_WIDTH-1:0] w_idx;
  logic [N_REQ-1:0]     w_next_onehot;

  assign grant_valid  = (r_state == S_GRANT);
  assign grant_onehot = r_grant_onehot;
  assign w_accept     = grant_valid & grant_ready;
  assign req_ack      = r_grant_onehot & {N_REQ{w_accept}};
  assign w_arb        = (r_state == S_IDLE) | w_accept;

  // A lock only holds while the accepted requestor still asks; otherwise
  // the accepted requestor is simply excluded for this arbitration.
  assign w_lock_hit = lock & w_accept & (|(req_ack & req));
  assign w_elig     = w_lock_hit ? (req_ack & req) : (req & ~req_ack);

  cci_mpf_prim_onehot_to_bin #(
    .ONEHOT_WIDTH (N_REQ),
    .BIN_WIDTH    (BIN_WIDTH)
  ) u_onehot_to_bin (
    .onehot (r_grant_onehot),
    .bin    (grant_bin)
  );

  // Pointer advances past the accepted index unless the grant is being locked;
  // the search already starts from the advanced pointer in the same cycle.
  always_comb begin
    w_ptr_next = r_ptr;
    if (w_accept && !lock) begin
      w_ptr_next = (grant_bin == c_last) ? '0 : grant_bin + BIN_WIDTH'(1);
    end
  end

  // Rotate eligible so the pointer lands on bit 0, then find the first set bit
  always_comb begin
    w_rot = N_REQ'({w_elig, w_elig} >> w_ptr_next);
    w_off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off = BIN_WIDTH'(i);
      end
    end
  end

  // Undo the rotation: add the pointer back, modulo N_REQ
  always_comb begin
    w_sum = {1'b0, w_ptr_next} + {1'b0, w_off};
    if (w_sum >= c_n_req_w) begin
      w_idx = BIN_WIDTH'(w_sum - c_n_req_w);
    end else begin
      w_idx = w_sum[BIN_WIDTH-1:0];
    end
    w_next_onehot = (|w_elig) ? (N_REQ'(1) << w_idx) : '0;
  end

  // Grant state machine: re-arbitrate when idle or on accept, else hold
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_grant_onehot <= '0;
      r_ptr          <= '0;
      r_locked       <= 1'b0;
    end else if (w_arb) begin
      r_grant_onehot <= w_next_onehot;
      r_state        <= (|w_elig) ? S_GRANT : S_IDLE;
      r_ptr          <= w_ptr_next;
      r_locked       <= w_lock_hit;
    end
  end

  a_onehot0 : assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(grant_onehot));
  a_valid_match : assert property (@(posedge clk) disable iff (!reset_n)
    grant_valid == (|grant_onehot));
  a_hold : assert property (@(posedge clk) disable iff (!reset_n)
    (grant_valid && !grant_ready) |=> $stable(grant_onehot));
  a_ack_zero : assert property (@(posedge clk) disable iff (!reset_n)
    !w_accept |-> (req_ack == '0));
  a_locked_valid : assert property (@(posedge clk) disable iff (!reset_n)
    r_locked |-> grant_valid);

endmodule : cci_mpf_prim_rr_arb_onehot
`default_nettype wire

// File: tb/tb_cci_mpf_prim_rr_arb_onehot.sv
`default_nettype none
// ============================================================================
// Module      : tb_cci_mpf_prim_rr_arb_onehot
// Description : Self-checking bench: vector table, corner sequences, and a
//               random soak against a round-robin reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cci_mpf_prim_rr_arb_onehot;

  localparam int N = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic          lock = 1'b0;
  logic          grant_ready = 1'b0;
  logic          grant_valid;
  logic [N-1:0]  grant_onehot;
  logic [3:0]    grant_bin;
  logic [N-1:0]  req_ack;

  int total = 0;
  int bad   = 0;

  // Reference model state: granted index (-1 = none) and search pointer
  int m_grant = -1;
  int m_ptr   = 0;

  typedef struct {
    bit          rst;
    logic [15:0] rq;
    logic        lk;
    logic        rdy;
    logic        ev;
    logic [15:0] eoh;
    logic [3:0]  eb;
    logic [15:0] ea;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  cci_mpf_prim_rr_arb_onehot #(.N_REQ(N)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req          (req),
    .lock         (lock),
    .grant_valid  (grant_valid),
    .grant_ready  (grant_ready),
    .grant_onehot (grant_onehot),
    .grant_bin    (grant_bin),
    .req_ack      (req_ack)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic add(input bit rst, input logic [15:0] rq, input logic lk, input logic rdy,
                     input logic ev, input logic [15:0] eoh, input logic [3:0] eb,
                     input logic [15:0] ea);
    vec_t v;
    v.rst = rst; v.rq = rq; v.lk = lk; v.rdy = rdy;
    v.ev = ev; v.eoh = eoh; v.eb = eb; v.ea = ea;
    tbl.push_back(v);
  endtask

  task automatic reset_dut();
    req = '0; lock = 1'b0; grant_ready = 1'b0;
    @(negedge clk) reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    m_grant = -1;
    m_ptr   = 0;
  endtask

  // Model outputs for the current cycle
  task automatic model_eval(input logic rdy, output logic v, output logic [15:0] oh,
                            output logic [3:0] b, output logic [15:0] a, output int acc);
    v   = (m_grant >= 0);
    oh  = v ? (16'h1 << m_grant) : 16'h0;
    b   = v ? 4'(m_grant) : 4'd0;
    a   = (v && rdy) ? oh : 16'h0;
    acc = (v && rdy) ? m_grant : -1;
  endtask

  // Model clock edge: round-robin pick starting just after the last accept
  task automatic model_step(input logic [15:0] rq, input logic lk, input logic rdy);
    bit accept;
    logic [15:0] el;
    int j;
    accept = (m_grant >= 0) && rdy;
    if ((m_grant >= 0) && !accept) return;
    el = rq;
    if (accept) begin
      if (lk && rq[m_grant]) el = 16'h1 << m_grant;
      else el[m_grant] = 1'b0;
      if (!lk) m_ptr = (m_grant + 1) % N;
    end
    m_grant = -1;
    for (int k = 0; k < N; k++) begin
      j = (m_ptr + k) % N;
      if (el[j]) begin
        m_grant = j;
        break;
      end
    end
  endtask

  task automatic run_cycle(input logic [15:0] rq, input logic lk, input logic rdy,
                           input bit use_model, input logic ev, input logic [15:0] eoh,
                           input logic [3:0] eb, input logic [15:0] ea,
                           input string tag, output int acc);
    logic xv; logic [15:0] xoh; logic [3:0] xb; logic [15:0] xa;
    @(negedge clk);
    req = rq; lock = lk; grant_ready = rdy;
    #1;
    model_eval(rdy, xv, xoh, xb, xa, acc);
    if (!use_model) begin
      xv = ev; xoh = eoh; xb = eb; xa = ea;
    end
    chk({tag, ".valid"}, 64'(grant_valid), 64'(xv));
    chk({tag, ".onehot"}, 64'(grant_onehot), 64'(xoh));
    chk({tag, ".bin"}, 64'(grant_bin), 64'(xb));
    chk({tag, ".ack"}, 64'(req_ack), 64'(xa));
    model_step(rq, lk, rdy);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    logic [15:0] pend;
    int waitc[N];
    int maxw;

    // Alternating pair, backpressure hold, wrap, lock
    add(1, 16'h0005, 0, 1, 0, 16'h0000, 4'd0, 16'h0000);
    add(0, 16'h0005, 0, 1, 1, 16'h0001, 4'd0, 16'h0001);
    add(0, 16'h0005, 0, 1, 1, 16'h0004, 4'd2, 16'h0004);
    add(0, 16'h0005, 0, 1, 1, 16'h0001, 4'd0, 16'h0001);
    add(0, 16'h0005, 0, 1, 1, 16'h0004, 4'd2, 16'h0004);
    for (int i = 0; i < 5; i++) add(0, 16'h0003, 0, 0, 1, 16'h0001, 4'd0, 16'h0000);
    add(0, 16'h0003, 0, 1, 1, 16'h0001, 4'd0, 16'h0001);
    add(0, 16'h0003, 0, 0, 1, 16'h0002, 4'd1, 16'h0000);
    add(1, 16'h4000, 0, 1, 0, 16'h0000, 4'd0, 16'h0000);
    add(0, 16'h8001, 0, 1, 1, 16'h4000, 4'd14, 16'h4000);
    add(0, 16'h8001, 0, 1, 1, 16'h8000, 4'd15, 16'h8000);
    add(0, 16'h8003, 0, 1, 1, 16'h0001, 4'd0, 16'h0001);
    add(0, 16'h0000, 0, 0, 1, 16'h0002, 4'd1, 16'h0000);
    add(1, 16'h0011, 0, 1, 0, 16'h0000, 4'd0, 16'h0000);
    add(0, 16'h0011, 1, 1, 1, 16'h0001, 4'd0, 16'h0001);
    add(0, 16'h0011, 1, 1, 1, 16'h0001, 4'd0, 16'h0001);
    add(0, 16'h0011, 1, 1, 1, 16'h0001, 4'd0, 16'h0001);
    add(0, 16'h0011, 0, 1, 1, 16'h0001, 4'd0, 16'h0001);
    add(0, 16'h0011, 1, 1, 1, 16'h0010, 4'd4, 16'h0010);
    add(0, 16'h0001, 1, 1, 1, 16'h0010, 4'd4, 16'h0010);
    add(0, 16'h0010, 1, 1, 1, 16'h0001, 4'd0, 16'h0001);
    add(0, 16'h0000, 0, 1, 1, 16'h0010, 4'd4, 16'h0010);
    add(0, 16'h0000, 0, 1, 0, 16'h0000, 4'd0, 16'h0000);

    reset_dut();
    chk("reset.valid", 64'(grant_valid), 64'd0);
    chk("reset.onehot", 64'(grant_onehot), 64'd0);
    chk("reset.bin", 64'(grant_bin), 64'd0);

    foreach (tbl[i]) begin
      if (tbl[i].rst) reset_dut();
      run_cycle(tbl[i].rq, tbl[i].lk, tbl[i].rdy, 1'b0, tbl[i].ev, tbl[i].eoh,
                tbl[i].eb, tbl[i].ea, $sformatf("tbl%0d", i), acc);
    end

    // Full request load: one grant per cycle, 0..15 twice
    reset_dut();
    for (int k = 0; k < 33; k++) begin
      run_cycle(16'hFFFF, 1'b0, 1'b1, 1'b1, 0, 0, 0, 0, $sformatf("full%0d", k), acc);
      if (k > 0) chk($sformatf("full%0d.seq", k), 64'(grant_bin), 64'((k - 1) % N));
    end

    // Asynchronous reset while a grant is presented
    reset_dut();
    run_cycle(16'hFFFF, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0, "ar0", acc);
    run_cycle(16'hFFFF, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0, "ar1", acc);
    @(negedge clk);
    grant_ready = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk("arst.valid", 64'(grant_valid), 64'd0);
    chk("arst.onehot", 64'(grant_onehot), 64'd0);
    chk("arst.bin", 64'(grant_bin), 64'd0);
    chk("arst.ack", 64'(req_ack), 64'd0);
    req = '0; grant_ready = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    m_grant = -1; m_ptr = 0;
    run_cycle(16'hFFFF, 1'b0, 1'b1, 1'b1, 0, 0, 0, 0, "arel0", acc);
    run_cycle(16'hFFFF, 1'b0, 1'b1, 1'b1, 0, 0, 0, 0, "arel1", acc);
    chk("arel.first_bin", 64'(grant_bin), 64'd0);
    chk("arel.first_valid", 64'(grant_valid), 64'd1);

    // Random soak with lock and backpressure
    reset_dut();
    pend = '0; acc = -1;
    for (int c = 0; c < 600; c++) begin
      if (acc >= 0) pend[acc] = ($urandom_range(0, 1) == 0);
      for (int i = 0; i < N; i++) if (!pend[i] && $urandom_range(0, 3) == 0) pend[i] = 1'b1;
      run_cycle(pend, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0), 1'b1,
                0, 0, 0, 0, $sformatf("soakA%0d", c), acc);
    end

    // Unlocked soak with starvation tracking
    reset_dut();
    pend = '0; acc = -1; maxw = 0;
    for (int i = 0; i < N; i++) waitc[i] = 0;
    for (int c = 0; c < 600; c++) begin
      if (acc >= 0) pend[acc] = ($urandom_range(0, 1) == 0);
      for (int i = 0; i < N; i++) if (!pend[i] && $urandom_range(0, 2) == 0) pend[i] = 1'b1;
      run_cycle(pend, 1'b0, ($urandom_range(0, 3) != 0), 1'b1,
                0, 0, 0, 0, $sformatf("soakB%0d", c), acc);
      if (acc >= 0) begin
        for (int i = 0; i < N; i++) begin
          if (i == acc) waitc[i] = 0;
          else if (pend[i]) begin
            waitc[i]++;
            if (waitc[i] > maxw) maxw = waitc[i];
          end
        end
      end
    end
    total++;
    if (maxw > N - 1) begin
      bad++;
      $display("FAIL starvation: actual=%0d accepts waited, required<=%0d", maxw, N - 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_cci_mpf_prim_rr_arb_onehot
`default_nettype wire
